// File: rtl/vr16_isa_pkg.sv
// VR16 ISA constants, instruction field layout and helpers shared by the
// program loader and the instruction decoder.
package vr16_isa_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned IMM_W   = 4;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RA_LSB  = 10;
  localparam int unsigned RB_LSB  = 8;
  localparam int unsigned RC_LSB  = 6;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_STOREI = 4'b1000;
  localparam logic [OPC_W-1:0] OP_JUMP   = 4'b1001;
  localparam logic [OPC_W-1:0] OP_DELETE = 4'b1010;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'b1111;

  localparam logic [OPC_W-1:0] OP_RSV_LO = 4'b1011;
  localparam logic [OPC_W-1:0] OP_RSV_HI = 4'b1110;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] reg_a;
    logic [REG_W-1:0] reg_b;
    logic [REG_W-1:0] reg_c;
    logic [REG_W-1:0] reg_d;
    logic [IMM_W-1:0] imm;
  } instr_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

  // Place each field at its architectural bit position in the word.
  function automatic logic [INSTR_W-1:0] pack_instr(input instr_fields_t f);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = f.opcode;
    w[RA_LSB  +: REG_W] = f.reg_a;
    w[RB_LSB  +: REG_W] = f.reg_b;
    w[RC_LSB  +: REG_W] = f.reg_c;
    w[RD_LSB  +: REG_W] = f.reg_d;
    w[IMM_LSB +: IMM_W] = f.imm;
    return w;
  endfunction

  function automatic logic is_reserved(input logic [OPC_W-1:0] opc);
    return (opc >= OP_RSV_LO) && (opc <= OP_RSV_HI);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO for packed instruction words; DEPTH must be a power of two.
module enc_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/instruction_encoder.sv
// VR16 program loader: packs field tuples, buffers them and writes consecutive
// instruction-memory words. Define INSTR_ENC_CHECK_EN to drop reserved opcodes.
module instruction_encoder
  import vr16_isa_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [REG_W-1:0]   in_reg_a,
  input  logic [REG_W-1:0]   in_reg_b,
  input  logic [REG_W-1:0]   in_reg_c,
  input  logic [REG_W-1:0]   in_reg_d,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               test_stall,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    wr_count,
  output logic               err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  enc_state_t         state_q, state_d;
  instr_fields_t      fields;
  logic [INSTR_W-1:0] word_in, word_out;
  logic               fifo_full, fifo_empty;
  logic               accept, rsv, push, pop, start_ok;
  logic [ADDR_W-1:0]  addr_q;
  logic               mem_we_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic [ADDR_W:0]    wr_count_q;

  assign fields  = '{opcode: in_opcode, reg_a: in_reg_a, reg_b: in_reg_b,
                     reg_c: in_reg_c, reg_d: in_reg_d, imm: in_imm};
  assign word_in = pack_instr(fields);

  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state_q == ST_IDLE);

`ifdef INSTR_ENC_CHECK_EN
  assign rsv = is_reserved(in_opcode);
`else
  assign rsv = 1'b0;
`endif

  assign push = accept && !rsv;
  assign pop  = !fifo_empty && !test_stall &&
                ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  enc_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (word_in),
    .pop   (pop),
    .rdata (word_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // DRAIN waits for the final write strobe to retire before signalling done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && (in_opcode == OP_HALT)) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !mem_we_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_count_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_we_q <= pop;
      busy_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q   <= (state_d == ST_DONE);
      if (pop) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= word_out;
        addr_q      <= addr_q + ADDR_ONE;
        if (wr_count_q != '1) wr_count_q <= wr_count_q + CNT_ONE;
      end
      if (start_ok) begin
        addr_q     <= base_addr;
        wr_count_q <= '0;
        err_q      <= 1'b0;
      end
      if (accept && rsv) err_q <= 1'b1;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_count  = wr_count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: randomized tuples against a
// scoreboard of expected {address, word} writes.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, test_stall;
  logic [7:0]  base_addr;
  logic [3:0]  in_opcode, in_imm;
  logic [1:0]  in_reg_a, in_reg_b, in_reg_c, in_reg_d;
  logic        mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  wr_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [7:0]  m_addr;
  int          m_cnt;
  bit          m_err;
  int          done_cnt;

  instruction_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_reg_c(in_reg_c),
    .in_reg_d(in_reg_d), .in_imm(in_imm), .test_stall(test_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
    if (done === 1'b1) done_cnt++;
  end

  function automatic void model_start(input logic [7:0] base);
    m_addr = base; m_cnt = 0; m_err = 0;
    exp_q.delete(); got_q.delete(); done_cnt = 0;
  endfunction

  function automatic void model_accept(input logic [3:0] op, input logic [1:0] a, b, c, d,
                                       input logic [3:0] imm);
    int w;
    w = int'(op) * 4096 + int'(a) * 1024 + int'(b) * 256 + int'(c) * 64 + int'(d) * 16 + int'(imm);
`ifdef INSTR_ENC_CHECK_EN
    if (op >= 4'd11 && op <= 4'd14) begin
      m_err = 1;
      return;
    end
`endif
    exp_q.push_back({m_addr, 16'(w)});
    m_addr = 8'((int'(m_addr) + 1) % 256);
    if (m_cnt < 511) m_cnt++;
  endfunction

  task automatic begin_session(input logic [7:0] base);
    @(negedge clk);
    start = 1'b1; base_addr = base;
    @(posedge clk);
    #1 start = 1'b0; base_addr = 8'($urandom);
    model_start(base);
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] a, b, c, d,
                      input logic [3:0] imm, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_reg_a = a; in_reg_b = b;
    in_reg_c = c; in_reg_d = d; in_imm = imm;
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready === 1'b1) begin
      @(posedge clk);
      model_accept(op, a, b, c, d, imm);
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand(input int max_op, output int waited);
    send(4'($urandom_range(0, max_op)), 2'($urandom), 2'($urandom), 2'($urandom),
         2'($urandom), 4'($urandom), waited);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 500);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int w;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_we, busy, done, err, in_ready, mem_addr, mem_wdata, wr_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b busy=%b done=%b err=%b rdy=%b addr=%h data=%h cnt=%0d, required all 0",
               mem_we, busy, done, err, in_ready, mem_addr, mem_wdata, wr_count);
    end
    reset = 1'b0;
    begin_session(8'h20);
    test_stall = 1'b1;
    repeat (3) send_rand(10, w);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_we, busy, done, err, in_ready, mem_addr, mem_wdata, wr_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid_session: we=%b busy=%b rdy=%b cnt=%0d, required all 0",
               mem_we, busy, in_ready, wr_count);
    end
    reset = 1'b0; test_stall = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_writes: %0d writes after reset, required 0", got_q.size());
    end
    begin_session(8'h30);
    send(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("reset_flush");
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 24'h30F000) begin
      errors++;
      $display("FAIL reset_fifo_empty: %0d writes first=%h, required 1 write 30F000",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'h0);
    end
  endtask

  task automatic test_basic();
    int w;
    begin_session(8'h10);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b, required 1", busy);
    end
    send(4'b1000, 2'b01, 2'b10, 2'b11, 2'b00, 4'b0101, w);
    send(4'b1111, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("basic");
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 24'h1086C5 || got_q[1] !== 24'h11F000) begin
      errors++;
      $display("FAIL basic_writes: %0d writes, first=%h, required 1086C5 then 11F000",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'h0);
    end
    checks++;
    if (wr_count !== 9'd2 || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: wr_count=%0d done_pulses=%0d busy=%b, required 2/1/0",
               wr_count, done_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    int w, max_w, w5;
    logic [3:0] op5;
    begin_session(8'($urandom));
    max_w = 0;
    for (int i = 0; i < 6; i++) begin
      send_rand(10, w);
      if (w > max_w) max_w = w;
    end
    checks++;
    if (max_w != 0) begin
      errors++;
      $display("FAIL bp_stream_ready: in_ready dropped for %0d cycles, required 0", max_w);
    end
    repeat (3) @(negedge clk);
    test_stall = 1'b1;
    for (int i = 0; i < 4; i++) send_rand(10, w);
    op5 = 4'($urandom_range(0, 10));
    fork
      send(op5, 2'd1, 2'd2, 2'd3, 2'd1, 4'hA, w5);
      begin
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b mem_we=%b, required 0/0", in_ready, mem_we);
          end
        end
        test_stall = 1'b0;
      end
    join
    checks++;
    if (w5 < 3) begin
      errors++;
      $display("FAIL bp_stall_wait: waited %0d cycles, required >=3", w5);
    end
    send(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("bp");
    checks++;
    if (got_q.size() != exp_q.size() || wr_count !== 9'd12) begin
      errors++;
      $display("FAIL bp_count: %0d writes wr_count=%0d, required %0d/12", got_q.size(), wr_count, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int w;
    begin_session(8'hFE);
    send_rand(10, w);
    send_rand(10, w);
    send(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("wrap");
    checks++;
    if (got_q.size() != 3 || got_q[0][23:16] !== 8'hFE || got_q[1][23:16] !== 8'hFF ||
        got_q[2][23:16] !== 8'h00) begin
      errors++;
      $display("FAIL wrap_addr: %0d writes, required addresses FE FF 00", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_check();
    int w, exp_n;
    logic exp_e;
    begin_session(8'($urandom));
    send_rand(10, w);
    send(4'b1100, 2'd3, 2'd2, 2'd1, 2'd0, 4'h7, w);
    send_rand(10, w);
    send(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("check");
`ifdef INSTR_ENC_CHECK_EN
    exp_n = 3; exp_e = 1'b1;
`else
    exp_n = 4; exp_e = 1'b0;
`endif
    checks++;
    if (got_q.size() != exp_n || err !== exp_e || m_err != exp_e) begin
      errors++;
      $display("FAIL check_drop: %0d writes err=%b, required %0d writes err=%b", got_q.size(), err, exp_n, exp_e);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL check_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    begin_session(8'h00);
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL check_err_clear: err=%b after start, required 0", err);
    end
    send(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("check_clear");
  endtask

  task automatic test_start_busy();
    int w;
    logic [7:0] b;
    b = 8'($urandom_range(0, 8'h30));
    begin_session(b);
    send_rand(10, w);
    send_rand(10, w);
    @(negedge clk);
    start = 1'b1; base_addr = 8'h40;
    @(posedge clk);
    #1 start = 1'b0;
    send_rand(10, w);
    send_rand(10, w);
    send(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("start_busy");
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL start_busy_count: %0d writes, required 5", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL start_busy_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    b = 8'($urandom);
    @(negedge clk);
    start = 1'b1; base_addr = b; in_valid = 1'b1; in_opcode = 4'd1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_with_valid: in_ready=%b in IDLE, required 0", in_ready);
    end
    @(posedge clk);
    #1 start = 1'b0; in_valid = 1'b0;
    model_start(b);
    send(4'hF, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, w);
    wait_done("start_valid");
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {b, 16'hF000}) begin
      errors++;
      $display("FAIL start_with_valid_writes: %0d writes, required 1 write %h", got_q.size(), {b, 16'hF000});
    end
  endtask

  task automatic test_random();
    int w, len;
    for (int s = 0; s < 4; s++) begin
      begin_session(8'($urandom));
      len = $urandom_range(3, 9);
      for (int k = 0; k < len; k++) begin
        send_rand(14, w);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send(4'hF, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), w);
      wait_done("rand");
      checks++;
      if (got_q.size() != exp_q.size() || wr_count !== 9'(m_cnt) || err !== m_err) begin
        errors++;
        $display("FAIL rand_status[%0d]: %0d writes cnt=%0d err=%b, required %0d/%0d/%b",
                 s, got_q.size(), wr_count, err, exp_q.size(), m_cnt, m_err);
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_write[%0d][%0d]: got %h, required %h", s, i, got_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; test_stall = 1'b0;
    in_opcode = '0; in_reg_a = '0; in_reg_b = '0; in_reg_c = '0; in_reg_d = '0; in_imm = '0;
    done_cnt = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_check();
    test_start_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
